// File: rtl/boost_pkg.sv
// boost_pkg: shared definitions for the boost-calculation adder path.
// Holds the floating-point word width, the adder tree fan-in, the
// encoding of +0.0 used as padding, and the addend packer state type.
// No ports; imported by addend_bank and addend_packer.
package boost_pkg;

  localparam int FP_WIDTH = 32;
  localparam int TREE_LENGTH = 18;
  localparam logic [FP_WIDTH-1:0] FP_ZERO = 32'h0;

  typedef enum logic [1:0] {
    FILL,
    ISSUE,
    WAIT
  } packer_state_e;

endpackage

// File: rtl/addend_bank.sv
// addend_bank: LENGTH-slot register file holding one group of addends.
// Ports:
//   clk     - clock
//   rst     - synchronous active-high reset, clears every slot to +0.0
//   clr_i   - whole-bank clear to +0.0 (takes priority over a write)
//   we_i    - write enable for slot waddr_i
//   waddr_i - slot index to write, 0..LENGTH-1
//   wdata_i - addend written into the slot
//   bank_o  - all slots packed, slot k at bits [k*DATA_WIDTH +: DATA_WIDTH]
module addend_bank
  import boost_pkg::*;
#(
  parameter int DATA_WIDTH = FP_WIDTH,
  parameter int LENGTH     = TREE_LENGTH,
  parameter int CNT_W      = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr_i,
  input  logic                         we_i,
  input  logic [CNT_W-1:0]             waddr_i,
  input  logic [DATA_WIDTH-1:0]        wdata_i,
  output logic [DATA_WIDTH*LENGTH-1:0] bank_o
);

  logic [DATA_WIDTH-1:0] slot_q [LENGTH];

  // Clearing to +0.0 means slots never written for a short group still
  // contribute nothing to the tree's sum.
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      for (int k = 0; k < LENGTH; k++) begin
        slot_q[k] <= DATA_WIDTH'(FP_ZERO);
      end
    end else if (we_i) begin
      slot_q[waddr_i] <= wdata_i;
    end
  end

  for (genvar k = 0; k < LENGTH; k++) begin : gPack
    assign bank_o[k*DATA_WIDTH +: DATA_WIDTH] = slot_q[k];
  end

endmodule

// File: rtl/addend_packer.sv
// addend_packer: gathers a serial stream of single-precision addends into
// LENGTH-wide groups for the non-pipelined adder tree. A group closes when
// it is full or on s_last, is issued with a one-cycle m_valid pulse, and
// the packer then waits for m_done before the bank is reused.
// Build option: define ADDEND_PACKER_DBUF_EN for two ping-pong banks so a
// new group can fill while the tree works on the previous one.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   s_data    - incoming addend; s_valid qualifies it; s_last closes a set
//   s_ready   - an addend is accepted this cycle when s_valid && s_ready
//   m_addends - packed group, slot k at [k*DATA_WIDTH +: DATA_WIDTH]
//   m_valid   - one-cycle issue pulse to the tree
//   m_last    - issued group closes a set; stable with m_addends
//   m_done    - tree has consumed the issued group
//   err_done  - sticky: m_done seen while no group was waiting on the tree
module addend_packer
  import boost_pkg::*;
#(
  parameter int DATA_WIDTH = FP_WIDTH,
  parameter int LENGTH     = TREE_LENGTH,
  parameter int CNT_W      = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_WIDTH-1:0]        s_data,
  input  logic                         s_valid,
  input  logic                         s_last,
  output logic                         s_ready,
  output logic [DATA_WIDTH*LENGTH-1:0] m_addends,
  output logic                         m_valid,
  output logic                         m_last,
  input  logic                         m_done,
  output logic                         err_done
);

  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(LENGTH - 1);

  packer_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             errDone_q, errDone_d;
  logic             xfer;
  logic             closeNow;

  assign xfer     = s_valid && s_ready;
  assign closeNow = xfer && (s_last || (cnt_q == LAST_SLOT));
  assign err_done = errDone_q;
  // m_valid is gated by rst so an in-flight issue is dropped immediately.
  assign m_valid  = !rst && (state_q == ISSUE);

`ifdef ADDEND_PACKER_DBUF_EN

  logic [1:0] full_q, full_d;
  logic [1:0] last_q, last_d;
  logic       fillSel_q, fillSel_d;
  logic       issueSel_q, issueSel_d;
  logic [1:0] bankWe, bankClr;
  logic [DATA_WIDTH*LENGTH-1:0] bankData [2];

  for (genvar b = 0; b < 2; b++) begin : gBank
    addend_bank #(
      .DATA_WIDTH(DATA_WIDTH),
      .LENGTH    (LENGTH),
      .CNT_W     (CNT_W)
    ) uBank (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (bankClr[b]),
      .we_i   (bankWe[b]),
      .waddr_i(cnt_q),
      .wdata_i(s_data),
      .bank_o (bankData[b])
    );
  end

  assign s_ready   = !rst && !full_q[fillSel_q];
  assign m_addends = bankData[issueSel_q];
  assign m_last    = last_q[issueSel_q];

  // Fill side writes the bank under fillSel; issue side owns the bank under
  // issueSel. When the tree is idle both pointers name the same bank, so a
  // closing group issues on the next cycle. On m_done the other bank issues
  // straight away if it is full (or closing this cycle).
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    full_d     = full_q;
    last_d     = last_q;
    fillSel_d  = fillSel_q;
    issueSel_d = issueSel_q;
    bankWe     = '0;
    bankClr    = '0;
    errDone_d  = errDone_q || (m_done && (state_q != WAIT));

    if (xfer) begin
      bankWe[fillSel_q] = 1'b1;
      if (closeNow) begin
        full_d[fillSel_q] = 1'b1;
        last_d[fillSel_q] = s_last;
        fillSel_d         = !fillSel_q;
        cnt_d             = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    unique case (state_q)
      FILL: begin
        if (full_q[issueSel_q] || closeNow) begin
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (m_done) begin
          bankClr[issueSel_q] = 1'b1;
          full_d[issueSel_q]  = 1'b0;
          last_d[issueSel_q]  = 1'b0;
          issueSel_d          = !issueSel_q;
          state_d = (full_q[!issueSel_q] || closeNow) ? ISSUE : FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FILL;
      cnt_q      <= '0;
      full_q     <= '0;
      last_q     <= '0;
      fillSel_q  <= 1'b0;
      issueSel_q <= 1'b0;
      errDone_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      full_q     <= full_d;
      last_q     <= last_d;
      fillSel_q  <= fillSel_d;
      issueSel_q <= issueSel_d;
      errDone_q  <= errDone_d;
    end
  end

`else

  logic bankWe, bankClr;
  logic mLast_q, mLast_d;

  addend_bank #(
    .DATA_WIDTH(DATA_WIDTH),
    .LENGTH    (LENGTH),
    .CNT_W     (CNT_W)
  ) uBank (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (bankClr),
    .we_i   (bankWe),
    .waddr_i(cnt_q),
    .wdata_i(s_data),
    .bank_o (m_addends)
  );

  assign s_ready = !rst && (state_q == FILL);
  assign m_last  = mLast_q;

  // The count holds on the closing write so it never passes LENGTH-1; it is
  // reset together with the bank once the tree reports completion.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mLast_d   = mLast_q;
    bankWe    = 1'b0;
    bankClr   = 1'b0;
    errDone_d = errDone_q || (m_done && (state_q != WAIT));

    unique case (state_q)
      FILL: begin
        if (xfer) begin
          bankWe = 1'b1;
          if (closeNow) begin
            mLast_d = s_last;
            state_d = ISSUE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (m_done) begin
          bankClr = 1'b1;
          cnt_d   = '0;
          mLast_d = 1'b0;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FILL;
      cnt_q     <= '0;
      mLast_q   <= 1'b0;
      errDone_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mLast_q   <= mLast_d;
      errDone_q <= errDone_d;
    end
  end

`endif

endmodule

// File: tb/tb_addend_packer.sv
// tb_addend_packer: self-checking bench for addend_packer. A queue-based
// model of accepted addends, closed groups and the tree's busy status
// predicts s_ready, m_valid, err_done and the issued group every cycle;
// directed sequences pin the model with literal expectations.
module tb_addend_packer;

  localparam int DW  = 32;
  localparam int LEN = 18;
  localparam int VW  = DW * LEN;
`ifdef ADDEND_PACKER_DBUF_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif

  typedef struct {
    logic [VW-1:0] data;
    bit            last;
  } grp_t;

  logic          clk;
  logic          rst;
  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          s_last;
  logic          s_ready;
  logic [VW-1:0] m_addends;
  logic          m_valid;
  logic          m_last;
  logic          m_done;
  logic          err_done;

  logic doneAuto;
  logic doneManual;
  assign m_done = doneAuto | doneManual;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit running = 0;
  bit autoEn = 1;
  int doneDelay = 5;
  int lastDoneCyc = 0;
  int doneQ[$];

  grp_t          pend[$];
  logic [VW-1:0] curData = '0;
  int            curCnt = 0;
  bit            mIssuing = 0;
  bit            mWaiting = 0;
  bit            mErr = 0;

  logic [VW-1:0] capAdd[$];
  bit            capLast[$];
  int            capCyc[$];

  addend_packer dut (
    .clk      (clk),
    .rst      (rst),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_last   (s_last),
    .s_ready  (s_ready),
    .m_addends(m_addends),
    .m_valid  (m_valid),
    .m_last   (m_last),
    .m_done   (m_done),
    .err_done (err_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Compare current outputs against the model, then advance the model by the
  // inputs presented in this cycle (they are stable at the falling edge).
  initial begin : compareModel
    bit wasIssuing;
    bit readyNow;
    forever begin
      @(negedge clk);
      if (running) begin
        checkOutput("s_ready", s_ready, !rst && (pend.size() < NB));
        checkOutput("m_valid", m_valid, !rst && mIssuing);
        checkOutput("err_done", err_done, mErr);
        if (mIssuing || mWaiting) begin
          checkOutput("m_addends", m_addends, pend[0].data);
          checkOutput("m_last", m_last, pend[0].last);
        end
        if (m_valid === 1'b1) begin
          capAdd.push_back(m_addends);
          capLast.push_back(m_last);
          capCyc.push_back(cyc);
        end
      end
      if (rst) begin
        pend.delete();
        curData  = '0;
        curCnt   = 0;
        mIssuing = 0;
        mWaiting = 0;
        mErr     = 0;
      end else begin
        wasIssuing = mIssuing;
        readyNow   = pend.size() < NB;
        if (m_done && mWaiting) begin
          void'(pend.pop_front());
          mWaiting = 0;
        end else if (m_done) begin
          mErr = 1;
        end
        if (wasIssuing) begin
          mIssuing = 0;
          mWaiting = 1;
        end
        if (s_valid && readyNow) begin
          curData[curCnt*DW +: DW] = s_data;
          curCnt++;
          if (curCnt == LEN || s_last) begin
            pend.push_back('{data: curData, last: s_last});
            curData = '0;
            curCnt  = 0;
          end
        end
        if (!mWaiting && !wasIssuing && pend.size() > 0) mIssuing = 1;
      end
    end
  end

  // Adder tree stand-in: answers each issue with m_done after doneDelay cycles.
  initial begin : treeResponder
    bit aborted;
    doneAuto = 1'b0;
    forever begin
      @(negedge clk);
      if (autoEn && m_valid === 1'b1 && !rst) begin
        aborted = 0;
        repeat (doneDelay) begin
          @(posedge clk);
          if (rst) aborted = 1;
        end
        #1;
        if (!aborted && !rst) begin
          doneAuto = 1'b1;
          lastDoneCyc = cyc;
          doneQ.push_back(cyc);
          @(posedge clk);
          #1 doneAuto = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] time limit reached");
  end

  task automatic sendWord(input logic [DW-1:0] d, input bit l, output int xc);
    int guard;
    bit xf;
    guard = 0;
    xf = 0;
    xc = 0;
    s_data = d;
    s_last = l;
    s_valid = 1'b1;
    while (!xf && guard < 400) begin
      @(negedge clk);
      xf = s_valid && s_ready;
      xc = cyc;
      @(posedge clk);
      #1;
      guard++;
    end
    s_valid = 1'b0;
    s_last = 1'b0;
    if (!xf) checkOutput("transfer_seen", VW'(xf), VW'(1));
  endtask

  task automatic applyStimulus(input int nWords, input int lastPct);
    int xc;
    for (int i = 0; i < nWords; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      sendWord($urandom, (i == nWords - 1) || ($urandom_range(0, 99) < lastPct), xc);
    end
  endtask

  task automatic waitCaptures(input int n);
    int g = 0;
    while (capLast.size() < n && g < 3000) begin
      @(posedge clk);
      #1;
      g++;
    end
    if (capLast.size() < n) checkOutput("capture_count", VW'(capLast.size()), VW'(n));
  endtask

  task automatic waitDrain();
    int g = 0;
    while ((pend.size() != 0 || mIssuing || mWaiting || curCnt != 0) && g < 3000) begin
      @(posedge clk);
      #1;
      g++;
    end
    if (g >= 3000) checkOutput("drain", VW'(pend.size()), VW'(0));
  endtask

  initial begin : main
    int xc;
    int xFirst;
    int n0;
    int nd0;
    logic [VW-1:0] expV;

    rst = 1'b1;
    s_data = '0;
    s_valid = 1'b0;
    s_last = 1'b0;
    doneManual = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_s_ready", s_ready, '0);
    checkOutput("rst_m_valid", m_valid, '0);
    checkOutput("rst_m_last", m_last, '0);
    checkOutput("rst_m_addends", m_addends, '0);
    checkOutput("rst_err_done", err_done, '0);
    @(posedge clk);
    #1 rst = 1'b0;
    running = 1;
    @(negedge clk);
    checkOutput("post_rst_s_ready", s_ready, VW'(1));
    @(posedge clk);
    #1;

    // Full group of 1.0
    doneDelay = 5;
    n0 = capLast.size();
    for (int i = 0; i < LEN; i++) sendWord(32'h3F800000, i == LEN - 1, xc);
    waitCaptures(n0 + 1);
    expV = {18{32'h3F800000}};
    checkOutput("full_group_data", capAdd[n0], expV);
    checkOutput("full_group_last", VW'(capLast[n0]), VW'(1));
    checkOutput("full_group_latency", VW'(capCyc[n0]), VW'(xc + 1));
    waitDrain();

    // Short group 2.0, 3.0
    n0 = capLast.size();
    sendWord(32'h40000000, 1'b0, xc);
    sendWord(32'h40400000, 1'b1, xc);
    waitCaptures(n0 + 1);
    expV = '0;
    expV[31:0] = 32'h40000000;
    expV[63:32] = 32'h40400000;
    checkOutput("short_group_data", capAdd[n0], expV);
    checkOutput("short_group_last", VW'(capLast[n0]), VW'(1));
    waitDrain();

    // Long set of 40 addends
    doneDelay = 20;
    n0 = capLast.size();
    for (int i = 0; i < 40; i++) sendWord(DW'(i + 1), i == 39, xc);
    waitCaptures(n0 + 3);
    checkOutput("long_last0", VW'(capLast[n0]), VW'(0));
    checkOutput("long_last1", VW'(capLast[n0 + 1]), VW'(0));
    checkOutput("long_last2", VW'(capLast[n0 + 2]), VW'(1));
    expV = '0;
    for (int k = 0; k < 4; k++) expV[k*DW +: DW] = DW'(37 + k);
    checkOutput("long_group3_data", capAdd[n0 + 2], expV);
    waitDrain();

    // Backpressure: second word held across ISSUE and WAIT
    doneDelay = 10;
    n0 = capLast.size();
    sendWord(32'h12345678, 1'b1, xc);
    sendWord(32'hC0A00000, 1'b1, xc);
`ifndef ADDEND_PACKER_DBUF_EN
    checkOutput("held_xfer_cycle", VW'(xc), VW'(lastDoneCyc + 1));
`endif
    waitCaptures(n0 + 2);
    expV = '0;
    expV[31:0] = 32'hC0A00000;
    checkOutput("held_word_slot0", capAdd[n0 + 1], expV);
    waitDrain();

    // m_done while filling: flagged, partial group untouched
    doneDelay = 5;
    n0 = capLast.size();
    sendWord(32'h00000011, 1'b0, xc);
    doneManual = 1'b1;
    @(posedge clk);
    #1 doneManual = 1'b0;
    @(negedge clk);
    checkOutput("err_done_set", err_done, VW'(1));
    checkOutput("err_s_ready", s_ready, VW'(1));
    @(posedge clk);
    #1;
    sendWord(32'h00000022, 1'b1, xc);
    waitCaptures(n0 + 1);
    expV = '0;
    expV[31:0] = 32'h00000011;
    expV[63:32] = 32'h00000022;
    checkOutput("err_group_data", capAdd[n0], expV);
    waitDrain();

    // Reset while waiting on the tree
    autoEn = 0;
    n0 = capLast.size();
    sendWord(32'h00000005, 1'b1, xc);
    waitCaptures(n0 + 1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("wrst_m_valid", m_valid, '0);
    checkOutput("wrst_m_last", m_last, '0);
    checkOutput("wrst_m_addends", m_addends, '0);
    checkOutput("wrst_err_done", err_done, '0);
    checkOutput("wrst_s_ready", s_ready, '0);
    @(posedge clk);
    #1 rst = 1'b0;
    autoEn = 1;
    @(negedge clk);
    checkOutput("wrst_release_s_ready", s_ready, VW'(1));
    @(posedge clk);
    #1;
    n0 = capLast.size();
    sendWord(32'h00000007, 1'b1, xc);
    waitCaptures(n0 + 1);
    expV = '0;
    expV[31:0] = 32'h00000007;
    checkOutput("wrst_next_slot0", capAdd[n0], expV);
    waitDrain();

    // Randomized sets against the model
    for (int r = 0; r < 8; r++) begin
      doneDelay = $urandom_range(1, 6);
      applyStimulus($urandom_range(5, 60), 12);
      waitDrain();
    end

`ifdef ADDEND_PACKER_DBUF_EN
    // Back-to-back stream into the second bank while the first waits
    doneDelay = 25;
    n0 = capLast.size();
    nd0 = doneQ.size();
    xFirst = 0;
    for (int i = 0; i < 36; i++) begin
      sendWord(DW'(100 + i), i == 35, xc);
      if (i == 0) xFirst = xc;
    end
    checkOutput("dbuf_no_stall", VW'(xc), VW'(xFirst + 35));
    waitCaptures(n0 + 2);
    waitDrain();
    checkOutput("dbuf_issue_spacing", VW'(capCyc[n0 + 1]), VW'(doneQ[nd0] + 1));
`else
    nd0 = doneQ.size();
    xFirst = nd0;
`endif

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/addend_packer.md
Name: addend_packer

Overview:
- Upstream feeder for the 18-input floating-point adder tree in the boost calculation path.
- Collects a serial stream of IEEE-754 single-precision addends into one LENGTH-wide vector.
- Zero-pads a short final group and issues it with a one-cycle valid pulse.
- The tree's control is not pipelined, so the packer holds off the next issue until the tree reports completion.

Parameters:
- DATA_WIDTH, 32, width of one addend (IEEE-754 single).
- LENGTH, 18, addends per issued group; must match the adder tree.
- CNT_W, 5, slot counter width; must satisfy 2^CNT_W > LENGTH.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- s_data  in  DATA_WIDTH  incoming addend.
- s_valid  in  1  s_data valid.
- s_last  in  1  marks the final addend of a set; qualified by s_valid.
- s_ready  out  1  packer can accept an addend this cycle.
- m_addends  out  DATA_WIDTH*LENGTH  packed group; slot k is at bits [k*DATA_WIDTH +: DATA_WIDTH].
- m_valid  out  1  one-cycle issue pulse to the tree's valid_in.
- m_last  out  1  issued group closes a set; stable with m_addends.
- m_done  in  1  tree's valid_out; the issued group has been consumed.
- err_done  out  1  sticky; m_done arrived while not in WAIT.

Behaviour:
- Reset values: all outputs are 0. The bank is cleared to 0 and cnt to 0; the state is FILL.
- Handshake:
  - A transfer occurs when s_valid && s_ready.
  - s_ready = 1 only in FILL.
  - s_data and s_last are sampled on the transfer edge.
- FILL:
  - On each transfer, write s_data to slot cnt and increment cnt.
  - If cnt == LENGTH-1 or s_last is set on the transfer, go to ISSUE and latch m_last = s_last.
  - Unwritten slots stay 32'h0 (+0.0). Every group is therefore fully defined and padding does not change the sum.
- ISSUE:
  - Lasts exactly one cycle: m_valid = 1 and s_ready = 0.
  - Then go to WAIT.
- WAIT:
  - s_ready = 0.
  - m_addends and m_last are held stable.
  - On m_done, clear the bank to 0, set cnt = 0 and m_last = 0, and return to FILL. s_ready rises the cycle after m_done.
- Latency:
  - Last transfer to m_valid: 1 cycle.
  - m_done to first new acceptance: 1 cycle.
- Boundary conditions:
  - s_last on the first element issues a group with slot 0 = data and slots 1..17 = 0.
  - s_last on the 18th element produces one group with m_last = 1; no empty group follows.
  - A set longer than LENGTH produces groups with m_last = 0 until the group containing s_last.
  - m_done in FILL or ISSUE is ignored for state and sets err_done. err_done clears only on rst.
  - s_valid while s_ready = 0: no transfer; the source must hold its data.
- Reset mid-operation: an in-flight group is discarded and m_valid is not asserted; the next group starts at slot 0.
- cnt never exceeds LENGTH-1. No arithmetic is performed on data.

Optional Feature:
- Macro: ADDEND_PACKER_DBUF_EN.
- Defined:
  - Two banks (A/B) with a fill pointer and an issue pointer.
  - While one bank waits on m_done, the other fills and s_ready stays 1.
  - A full pending bank issues on the cycle after m_done, giving a minimum issue spacing of m_done + 1.
  - m_valid is never asserted in the same cycle as m_done.
  - s_ready = 0 only when both banks are full or waiting.
- Undefined: single bank, behaviour as above. The interface is identical in both builds.

Decomposition:
- Shared package boost_pkg:
  - FP_WIDTH = 32.
  - TREE_LENGTH = 18.
  - FP_ZERO = 32'h0.
  - Packer state enum {FILL, ISSUE, WAIT}.
- One natural sub-module, addend_bank: LENGTH-slot register file with indexed write and whole-bank clear. It is instantiated once, or twice under ADDEND_PACKER_DBUF_EN.

Test Plan:
- Full group: send 18 values 1.0 (32'h3F800000) with s_last on the 18th.
  - m_valid pulses 1 cycle after the last transfer; every slot = 3F800000; m_last = 1; s_ready = 0 until m_done + 1.
- Short group: send 2.0 then 3.0 (32'h40000000, 32'h40400000) with s_last on 3.0.
  - Slot 0 = 40000000, slot 1 = 40400000, slots 2..17 = 0, m_last = 1.
- Long set: send 40 addends with s_last on the 40th, pulsing m_done 20 cycles after each m_valid.
  - Three issues: m_last = 0, 0, 1; the third group has 4 data slots and 14 zero slots.
- Backpressure: hold s_valid = 1 through WAIT.
  - No transfers occur; s_data is not lost; the first transfer lands in slot 0 on the cycle after m_done.
- Errors and reset:
  - m_done pulsed in FILL → err_done = 1, state unchanged.
  - rst asserted during WAIT → all outputs 0, s_ready = 1 the cycle after rst falls.
- DBUF build: stream 36 addends back-to-back with s_valid held high.
  - s_ready stays 1 through the first WAIT; the second m_valid occurs exactly 1 cycle after the first m_done.
